mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 256x8 single-port memory.
- Accepts read/write requests from two requesters and serialises them into single-cycle memory accesses on the mem_rd/mem_wr/mem_addr/mem_din interface.
- Returns read data and a one-cycle acknowledge to the requester that won.
- Round-robin arbitration by default; fixed priority when the optional macro is defined.

Parameters:
- AW, 8, address width; must match the memory address width.
- DW, 8, data width; must match the memory data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 request; held high until ack0.
- we0  input  1  requester 0: 1 = write, 0 = read.
- addr0  input  AW  requester 0 address.
- wdata0  input  DW  requester 0 write data.
- ack0  output  1  one-cycle completion pulse to requester 0.
- req1, we1, addr1, wdata1, ack1  same as above, for requester 1.
- rdata  output  DW  read data for the completed read; valid in the ack cycle.
- busy  output  1  high whenever the FSM is not IDLE.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- mem_addr  output  AW  memory address.
- mem_din  output  DW  memory write data.
- mem_dout  input  DW  memory read data; combinational from mem_addr.

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM forced to IDLE.
  - ack0, ack1, mem_rd, mem_wr, busy = 0.
  - rdata, mem_addr, mem_din = 0.
  - last_gnt = 1, so requester 0 wins the first contention.
  - A reset mid-transaction aborts it: no ack is issued and the memory strobe drops immediately.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise select a winner:
    - Only one req high: that requester wins.
    - Both high: the requester other than last_gnt wins.
  - Latch the winner's we, addr and wdata into internal registers and store its index in gnt.
  - Go to ACCESS.
- ACCESS (exactly one cycle):
  - Drive mem_addr and mem_din from the latched values.
  - Assert mem_wr=1 if the latched we=1; otherwise assert mem_rd=1.
  - On a read, register mem_dout into rdata at the end of the cycle.
  - Go to DONE.
- DONE (one cycle):
  - Strobes are 0.
  - Pulse ack[gnt]=1; rdata holds the captured value (it is unchanged after a write).
  - Set last_gnt = gnt and go to IDLE.
- Latency: req sampled high in IDLE at cycle N -> strobe during N+1 -> ack at N+2.
- Throughput: one access per 3 cycles. A requester that holds req after its ack is re-arbitrated in IDLE at N+3.
- Request fields are sampled only in IDLE. Changes to we/addr/wdata, or dropping req, after the grant do not affect the in-flight access, and the ack is still issued.
- Requests arriving while busy wait in IDLE arbitration; none are lost as long as req stays high.
- mem_rd and mem_wr are never high in the same cycle, and are never high outside ACCESS.
- mem_addr and mem_din hold their last values outside ACCESS.
- Addresses use the full AW range; 8'hFF is a normal address. There is no wrap-around logic.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. When both req0 and req1 are high in IDLE, requester 0 always wins; last_gnt is ignored but still updated.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset then write: assert rst, release; req0=1, we0=1, addr0=8'h10, wdata0=8'hA5.
  - Required: mem_wr=1 with mem_addr=8'h10 and mem_din=8'hA5 one cycle after the request is sampled; ack0 pulses the cycle after that; busy=1 across ACCESS and DONE.
- Read-back: req1=1, we1=0, addr1=8'h10.
  - Required: mem_rd=1 in ACCESS; ack1 pulses with rdata=8'hA5; ack0 stays 0.
- Contention, round-robin (macro undefined): req0 and req1 held high continuously from reset.
  - Required: grants alternate 0,1,0,1; ack pulses spaced 3 cycles apart.
- Contention, fixed priority (MEM_ARB_FIXED_PRIO_EN defined): same stimulus as above.
  - Required: only ack0 pulses while req0 is held high; ack1 pulses only after req0 drops.
- Field change after grant: req0 write to addr0=8'h20 with wdata0=8'h3C; change addr0 to 8'h21 in the ACCESS cycle.
  - Required: memory location 8'h20 = 8'h3C; location 8'h21 unchanged; ack0 issued.
- Reset mid-operation: assert rst during the ACCESS cycle of a write.
  - Required: mem_wr drops to 0 immediately; no ack is issued; after release, the FSM is in IDLE and requester 0 wins the next contention.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter/sequencer in front of a single-port
// memory. Each granted request becomes one single-cycle memory access
// (IDLE -> ACCESS -> DONE) followed by a one-cycle ack to the winner.
// Arbitration is round-robin by default; defining MEM_ARB_FIXED_PRIO_EN
// gives requester 0 fixed priority under contention.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          gnt_r;       // index of the requester currently served
  logic          last_gnt_r;  // index served by the previous access
  logic          we_r;        // latched direction of the in-flight access
  logic          grant_s;     // a winner is chosen this cycle
  logic          win_s;       // index of that winner
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  // Next-state and winner selection; request fields only matter in IDLE.
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    win_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          grant_s = 1'b1;
          state_s = ACCESS;
          if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            win_s = 1'b0;
`else
            win_s = ~last_gnt_r;
`endif
          end else if (req1) begin
            win_s = 1'b1;
          end else begin
            win_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS:  state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Multiplex the winner's request fields for latching.
  always_comb begin
    if (win_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered datapath and outputs; the address/data registers double as
  // the latched request and hold their value outside ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r      <= 1'b0;
      last_gnt_r <= 1'b1;
      we_r       <= 1'b0;
      mem_addr   <= {AW{1'b0}};
      mem_din    <= {DW{1'b0}};
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      rdata      <= {DW{1'b0}};
    end else begin
      mem_rd <= grant_s & ~sel_we_s;
      mem_wr <= grant_s & sel_we_s;
      busy   <= (state_s != IDLE);
      ack0   <= (state_r == ACCESS) && !gnt_r;
      ack1   <= (state_r == ACCESS) && gnt_r;
      if (grant_s) begin
        gnt_r    <= win_s;
        we_r     <= sel_we_s;
        mem_addr <= sel_addr_s;
        mem_din  <= sel_wdata_s;
      end
      if ((state_r == ACCESS) && !we_r) begin
        rdata <= mem_dout;
      end
      if (state_r == DONE) begin
        last_gnt_r <= gnt_r;
      end
    end
  end

endmodule
